// File: rtl/dec_pkg.sv
// Shared types and constants for the registered 3-to-8 hold decoder.
// Holds the FSM state encoding and the one-hot helper.
package dec_pkg;

    localparam int DEC_N  = 8;
    localparam int CODE_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } state_t;

    function automatic logic [DEC_N-1:0] onehot(input logic [CODE_W-1:0] code);
        logic [DEC_N-1:0] v;
        v       = '0;
        v[code] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/hold_counter.sv
// Down-counter with load, clear and zero flag, shared by the HOLD and GAP phases.
// It saturates at zero, so a stray decrement can never wrap around.
module hold_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             zero
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/decoder_3x8_hold.sv
// Registered 3-to-8 decoder: accepts a code over valid/ready, holds its one-hot
// line for HOLD_CYCLES cycles, then forces GAP_CYCLES all-zero cycles.
module decoder_3x8_hold
    import dec_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 1,
    parameter int CNT_W       = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic in_valid,
    output logic in_ready,
    input  logic b0,
    input  logic b1,
    input  logic b2,
    output logic d0,
    output logic d1,
    output logic d2,
    output logic d3,
    output logic d4,
    output logic d5,
    output logic d6,
    output logic d7,
    output logic busy,
    output logic done
);

    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;

    state_t              state, state_n;
    logic [CODE_W-1:0]   code_q, code_n, code_in;
    logic [DEC_N-1:0]    d_q, d_n;
    logic                done_q, done_n;
    logic                load, dec, clr, zero;
    logic [CNT_W-1:0]    load_val, cnt;

    assign code_in = {b2, b1, b0};

    hold_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .load     (load),
        .load_val (load_val),
        .dec      (dec),
        .cnt      (cnt),
        .zero     (zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            code_q <= '0;
            d_q    <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_n;
            code_q <= code_n;
            d_q    <= d_n;
            done_q <= done_n;
        end
    end

    // done is registered one cycle early so it lines up with the last HOLD cycle.
    always_comb begin
        state_n  = state;
        code_n   = code_q;
        load     = 1'b0;
        load_val = '0;
        dec      = 1'b0;
        clr      = 1'b0;
        done_n   = 1'b0;
        if (!en) begin
            state_n = IDLE;
            clr     = 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        state_n  = HOLD;
                        code_n   = code_in;
                        load     = 1'b1;
                        load_val = HOLD_LOAD;
                        done_n   = (HOLD_CYCLES == 1);
                    end
                end
                HOLD: begin
                    if (zero) begin
                        if (GAP_CYCLES > 0) begin
                            state_n  = GAP;
                            load     = 1'b1;
                            load_val = GAP_LOAD;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        dec    = 1'b1;
                        done_n = (cnt == CNT_W'(1));
                    end
                end
                GAP: begin
                    if (zero) state_n = IDLE;
                    else      dec     = 1'b1;
                end
                default: state_n = IDLE;
            endcase
        end
        d_n = (state_n == HOLD) ? onehot(code_n) : '0;
    end

    assign in_ready = en && (state == IDLE);
    assign busy     = (state != IDLE);
    assign done     = done_q;
    assign {d7, d6, d5, d4, d3, d2, d1, d0} = d_q;

endmodule
